// File: rtl/axi_streams_arb_pkg.sv
// Shared types and helpers for the scaler arbiter: FSM state encoding,
// one-hot to index conversion and the requester-count ceiling.
package axi_streams_arb_pkg;

    localparam int MAX_NUM = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    function automatic logic [3:0] onehot2idx(input logic [MAX_NUM-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NUM; i++)
            if (oh[i]) idx = idx | 4'(i);
        return idx;
    endfunction

endpackage

// File: rtl/axi_streams_scaler_arb_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping at NUM-1 (NUM need not be a power of two).
module rr_onehot_pick
    import axi_streams_arb_pkg::*;
#(
    parameter int NUM = 4,
    parameter int IW  = $clog2(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NUM-1:0] win_oh,
    output logic [IW-1:0]  win_idx,
    output logic           win_found
);

    always_comb begin
        logic [IW:0]   pos;
        logic [IW-1:0] idx;
        logic          hit;
        win_oh = '0;
        hit    = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos > (IW+1)'(NUM-1))
                pos = pos - (IW+1)'(NUM);
            idx = pos[IW-1:0];
            if (!hit && req[idx]) begin
                win_oh[idx] = 1'b1;
                hit         = 1'b1;
            end
        end
        win_found = hit;
    end

    assign win_idx = IW'(onehot2idx(MAX_NUM'(win_oh)));

endmodule

// File: rtl/axi_streams_scaler_arb.sv
// Round-robin arbiter sharing one scaler between NUM requesters.
// Define SCALER_ARB_TIMEOUT_EN to add a BUSY watchdog that force-releases the grant.
module axi_streams_scaler_arb
    import axi_streams_arb_pkg::*;
#(
    parameter int NUM     = 4,
    parameter int LSIZE   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic [NUM-1:0]            req,
    input  logic [NUM-1:0][LSIZE-1:0] req_len,
    input  logic                      m_last_acc,
    output logic [NUM-1:0]            grant,
    output logic                      grant_vld,
    output logic [LSIZE-1:0]          new_body_len,
    output logic [NUM-1:0]            reject,
    output logic                      timeout_err
);

    localparam int IW = $clog2(NUM);
`ifdef SCALER_ARB_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    arb_state_e       state, state_nxt;
    logic [IW-1:0]    ptr, ptr_nxt, ptr_inc, win_idx;
    logic [NUM-1:0]   win_oh, grant_nxt, reject_nxt;
    logic             win_found, busy_to, to_nxt;
    logic [LSIZE-1:0] win_len, len_nxt;

    rr_onehot_pick #(.NUM(NUM), .IW(IW)) u_pick (
        .req       (req),
        .ptr       (ptr),
        .win_oh    (win_oh),
        .win_idx   (win_idx),
        .win_found (win_found)
    );

    assign win_len = req_len[win_idx];
    assign ptr_inc = (win_idx == IW'(NUM-1)) ? '0 : win_idx + IW'(1);

    generate
        if (WD_EN) begin : g_wd
            // Counts BUSY cycles without frame completion; idles at 0 elsewhere.
            logic [15:0] wd_cnt;
            always_ff @(posedge clock or posedge rst) begin
                if (rst)
                    wd_cnt <= '0;
                else if (clk_en) begin
                    if (state != BUSY)
                        wd_cnt <= '0;
                    else if (!m_last_acc)
                        wd_cnt <= wd_cnt + 16'd1;
                end
            end
            assign busy_to = (state == BUSY) && !m_last_acc && (wd_cnt == 16'(TIMEOUT-1));
        end else begin : g_no_wd
            assign busy_to = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            grant        <= '0;
            new_body_len <= '0;
            reject       <= '0;
            timeout_err  <= 1'b0;
        end else if (clk_en) begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            grant        <= grant_nxt;
            new_body_len <= len_nxt;
            reject       <= reject_nxt;
            timeout_err  <= to_nxt;
        end else begin
            // Pulses must not stretch across a stalled cycle.
            reject      <= '0;
            timeout_err <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (|req) state_nxt = PICK;
            PICK: state_nxt = (win_found && win_len != '0) ? BUSY : IDLE;
            BUSY: if (m_last_acc || busy_to) state_nxt = GAP;
            GAP:  state_nxt = (|req) ? PICK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_nxt  = grant;
        len_nxt    = new_body_len;
        ptr_nxt    = ptr;
        reject_nxt = '0;
        to_nxt     = 1'b0;
        unique case (state)
            PICK: if (win_found) begin
                ptr_nxt = ptr_inc;
                if (win_len != '0) begin
                    grant_nxt = win_oh;
                    len_nxt   = win_len;
                end else begin
                    reject_nxt = win_oh;
                end
            end
            BUSY: if (m_last_acc || busy_to) begin
                grant_nxt = '0;
                to_nxt    = busy_to;
            end
            default: ;
        endcase
    end

    assign grant_vld = |grant;

endmodule

// File: tb/tb_axi_streams_scaler_arb.sv
// Directed + randomized bench for axi_streams_scaler_arb against a
// transaction-level model (busy owner / pending decision / round-robin pointer).
module tb_axi_streams_scaler_arb;

    localparam int NUM     = 4;
    localparam int LSIZE   = 16;
    localparam int TIMEOUT = 16;
`ifdef SCALER_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                      clock = 1'b0;
    logic                      rst;
    logic                      clk_en;
    logic [NUM-1:0]            req;
    logic [NUM-1:0][LSIZE-1:0] req_len;
    logic                      m_last_acc;
    logic [NUM-1:0]            grant;
    logic                      grant_vld;
    logic [LSIZE-1:0]          new_body_len;
    logic [NUM-1:0]            reject;
    logic                      timeout_err;

    always #5 clock = ~clock;

    axi_streams_scaler_arb #(.NUM(NUM), .LSIZE(LSIZE), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .rst          (rst),
        .clk_en       (clk_en),
        .req          (req),
        .req_len      (req_len),
        .m_last_acc   (m_last_acc),
        .grant        (grant),
        .grant_vld    (grant_vld),
        .new_body_len (new_body_len),
        .reject       (reject),
        .timeout_err  (timeout_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: who owns the scaler, whether a decision is due at the
    // next enabled edge, and the round-robin start point.
    int               m_owner, m_ptr, m_busy;
    bit               m_decide;
    logic [NUM-1:0]   e_grant, e_reject;
    logic [LSIZE-1:0] e_len;
    logic             e_to;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_busy = 0; m_decide = 1'b0;
        e_grant = '0; e_reject = '0; e_len = '0; e_to = 1'b0;
    endtask

    task automatic model_step();
        int w;
        e_reject = '0;
        e_to     = 1'b0;
        if (!clk_en) return;
        if (m_owner >= 0) begin
            m_busy++;
            if (m_last_acc || (TO_EN && m_busy == TIMEOUT)) begin
                e_to    = !m_last_acc;
                m_owner = -1;
                e_grant = '0;
            end
        end else if (m_decide) begin
            m_decide = 1'b0;
            w = -1;
            for (int k = 0; k < NUM; k++)
                if (w < 0 && req[(m_ptr + k) % NUM]) w = (m_ptr + k) % NUM;
            if (w >= 0) begin
                m_ptr = (w + 1) % NUM;
                if (req_len[w] == 0) e_reject[w] = 1'b1;
                else begin
                    m_owner = w; m_busy = 0;
                    e_grant = '0; e_grant[w] = 1'b1;
                    e_len = req_len[w];
                end
            end
        end else begin
            m_decide = |req;
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clock);
        chk("grant", grant, e_grant);
        chk("grant_vld", grant_vld, |e_grant);
        chk("new_body_len", new_body_len, e_len);
        chk("reject", reject, e_reject);
        chk("timeout_err", timeout_err, e_to);
    endtask

    task automatic release_frame();
        m_last_acc = 1'b1; tick(); m_last_acc = 1'b0;
    endtask

    initial begin
        int idle;
        rst = 1'b1; clk_en = 1'b1; req = '0; req_len = '0; m_last_acc = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        chk("rst_grant", grant, 0);
        chk("rst_len", new_body_len, 0);
        chk("rst_reject", reject, 0);
        chk("rst_to", timeout_err, 0);
        rst = 1'b0;

        // All four requesting continuously from ptr=0
        req = '1;
        for (int i = 0; i < NUM; i++) req_len[i] = LSIZE'(10 + i);
        for (int g = 0; g < 5; g++) begin
            idle = 0;
            while (grant === '0 && idle < 10) begin idle++; tick(); end
            chk("rr_gap", idle, 2);
            chk("rr_order", grant, 1 << (g % NUM));
            chk("rr_len", new_body_len, 10 + (g % NUM));
            repeat (2) tick();
            release_frame();
        end
        req = '0;
        repeat (3) tick();

        // Single request, withdrawn once granted
        req = 4'b0100; req_len[2] = 100;
        repeat (2) tick();
        chk("single_grant", grant, 4'b0100);
        chk("single_len", new_body_len, 100);
        req = '0;
        repeat (12) tick();
        chk("withdrawn_hold", grant, 4'b0100);
        release_frame();
        chk("single_drop", grant, 0);
        repeat (2) tick();

        // Zero length: ptr is 3, search reaches 1 and rejects it
        req = 4'b0010; req_len[1] = 0;
        repeat (2) tick();
        chk("zero_reject", reject, 4'b0010);
        chk("zero_nogrant", grant, 0);
        req = '0;
        tick();
        chk("zero_pulse_end", reject, 0);
        req = 4'b0101; req_len[0] = 5; req_len[2] = 6;
        repeat (2) tick();
        chk("after_reject_ptr", grant, 4'b0100);
        req = 4'b0001;
        tick();
        release_frame();
        repeat (4) tick();
        req = '0;
        tick();
        release_frame();
        repeat (2) tick();

        // Reset mid-BUSY, then req[3] alone from ptr=0
        req = 4'b0001; req_len[0] = 9;
        repeat (2) tick();
        req = '0;
        tick();
        #2 rst = 1'b1;
        #1 chk("rst_async_grant", grant, 0);
        @(negedge clock);
        rst = 1'b0;
        model_reset();
        req = 4'b1000; req_len[3] = 7;
        repeat (2) tick();
        chk("post_rst_grant", grant, 4'b1000);
        chk("post_rst_len", new_body_len, 7);
        req = '0;

        // No frame completion: watchdog release or indefinite hold
        repeat (40) tick();
        chk("hold_or_timeout", grant, TO_EN ? 32'h0 : 32'h8);
        release_frame();
        repeat (2) tick();

        // Randomized traffic with stalls and stray m_last_acc
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM; i++) begin
                if (req[i] && (e_grant[i] || e_reject[i] || $urandom_range(63) == 0))
                    req[i] = 1'b0;
                else if (!req[i] && !e_grant[i] && $urandom_range(7) == 0) begin
                    req[i] = 1'b1;
                    req_len[i] = ($urandom_range(5) == 0) ? '0 : LSIZE'($urandom_range(500, 1));
                end
            end
            m_last_acc = ($urandom_range(4) == 0);
            clk_en     = ($urandom_range(7) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
